// File: rtl/alu_pkg.sv
// Shared opcode constants, flag bit positions and controller state encoding
// for the ALU sequencing controller and its surrounding top level.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_SHL  = 4'h4;
  localparam logic [3:0] OP_SHR  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_XNOR = 4'h9;
  localparam logic [3:0] OP_NAND = 4'hA;
  localparam logic [3:0] OP_NOR  = 4'hB;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_UNF   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Opcodes above NOR are reserved; the controller passes them through untouched.
  function automatic logic op_defined(input logic [3:0] op);
    return op <= OP_NOR;
  endfunction

endpackage

// File: rtl/alu_ctrl_if.sv
// Request/ALU/response bus of the ALU controller. slave = controller side,
// master = requester, ALU and response consumer side.
interface alu_ctrl_if;

  logic       REQ_VALID;
  logic       REQ_READY;
  logic [3:0] REQ_SEL;
  logic [7:0] REQ_A;
  logic [7:0] REQ_B;
  logic [3:0] SEL_TMP;
  logic [7:0] A;
  logic [7:0] B;
  logic [7:0] ALU_OUT_TMP;
  logic [3:0] FLAG_TMP;
  logic       RSP_VALID;
  logic       RSP_READY;
  logic [7:0] RSP_DATA;
  logic [3:0] RSP_FLAGS;

  modport slave (
    input  REQ_VALID, REQ_SEL, REQ_A, REQ_B, ALU_OUT_TMP, FLAG_TMP, RSP_READY,
    output REQ_READY, SEL_TMP, A, B, RSP_VALID, RSP_DATA, RSP_FLAGS
  );

  modport master (
    output REQ_VALID, REQ_SEL, REQ_A, REQ_B, ALU_OUT_TMP, FLAG_TMP, RSP_READY,
    input  REQ_READY, SEL_TMP, A, B, RSP_VALID, RSP_DATA, RSP_FLAGS
  );

endinterface

// File: rtl/alu_ctrl.sv
// Sequences one operation at a time through an external combinational ALU.
// Optional sticky flag accumulation enabled by ALU_CTRL_STICKY_FLAGS_EN.
//
// state   | meaning
// IDLE    | ready for a request, operands latched on REQ_VALID
// EXEC    | operands held on A/B/SEL_TMP while the ALU settles
// RESP    | result captured, RSP_VALID held until RSP_READY
module alu_ctrl
  import alu_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  alu_ctrl_if.slave        bus,
  output logic [CNT_W-1:0] OP_COUNT,
  output logic [3:0]       STICKY_FLAGS,
  input  logic             STICKY_CLR
);

  state_e           state_q, state_d;
  logic [3:0]       sel_q, sel_d;
  logic [7:0]       a_q, a_d;
  logic [7:0]       b_q, b_d;
  logic [7:0]       data_q, data_d;
  logic [3:0]       flags_q, flags_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             capture;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      flags_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    a_d     = a_q;
    b_d     = b_q;
    data_d  = data_q;
    flags_d = flags_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.REQ_VALID) begin
          sel_d   = bus.REQ_SEL;
          a_d     = bus.REQ_A;
          b_d     = bus.REQ_B;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        capture = 1'b1;
        data_d  = bus.ALU_OUT_TMP;
        flags_d = bus.FLAG_TMP;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.RSP_READY) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Ready is masked by reset so a requester never sees a handshake mid-reset.
  assign bus.REQ_READY = (state_q == ST_IDLE) && !RESET;
  assign bus.RSP_VALID = (state_q == ST_RESP);
  assign bus.SEL_TMP   = sel_q;
  assign bus.A         = a_q;
  assign bus.B         = b_q;
  assign bus.RSP_DATA  = data_q;
  assign bus.RSP_FLAGS = flags_q;
  assign OP_COUNT      = cnt_q;

`ifdef ALU_CTRL_STICKY_FLAGS_EN
  logic [3:0] sticky_q, sticky_d;

  // Clear applies first so a simultaneous capture leaves only the new flags.
  always_comb begin
    sticky_d = STICKY_CLR ? 4'b0000 : sticky_q;
    if (capture) sticky_d = sticky_d | bus.FLAG_TMP;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) sticky_q <= '0;
    else       sticky_q <= sticky_d;
  end

  assign STICKY_FLAGS = sticky_q;
`else
  logic unused_sticky;
  assign unused_sticky = STICKY_CLR | capture;
  assign STICKY_FLAGS  = 4'b0000;
`endif

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl: vector table plus stall, reset, sticky and
// counter-wrap sequences. A behavioural ALU sits beside the controller.
module tb_alu_ctrl;
  import alu_pkg::*;

`ifdef ALU_CTRL_STICKY_FLAGS_EN
  localparam bit STICKY_ON = 1'b1;
`else
  localparam bit STICKY_ON = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] op_count;
  logic [3:0] sticky_flags;
  logic       sticky_clr;

  alu_ctrl_if bus ();

  alu_ctrl #(.CNT_W(8)) dut (
    .CLK          (clk),
    .RESET        (rst),
    .bus          (bus),
    .OP_COUNT     (op_count),
    .STICKY_FLAGS (sticky_flags),
    .STICKY_CLR   (sticky_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stand-in for the external ALU: {flags, result}.
  function automatic logic [11:0] alu_model(input logic [3:0] op, input logic [7:0] a,
                                            input logic [7:0] b);
    logic [8:0]  s;
    logic [15:0] p;
    logic [7:0]  r;
    logic [3:0]  f;
    r = 8'h00;
    f = 4'h0;
    s = 9'h000;
    p = 16'h0000;
    case (op)
      OP_ADD:  begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; f[FLAG_CARRY] = s[8]; end
      OP_SUB:  begin r = a - b; f[FLAG_UNF] = (a < b); end
      OP_MUL:  begin p = a * b; r = p[7:0]; f[FLAG_OVF] = (p > 16'd255); end
      OP_DIV:  begin
        if (b == 8'd0) begin r = 8'hFF; f[FLAG_OVF] = 1'b1; end
        else r = a / b;
      end
      OP_SHL:  r = a << b[2:0];
      OP_SHR:  r = a >> b[2:0];
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_XNOR: r = ~(a ^ b);
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      default: r = 8'h00;
    endcase
    if (op_defined(op)) f[FLAG_ZERO] = (r == 8'h00);
    return {f, r};
  endfunction

  always_comb begin
    {bus.FLAG_TMP, bus.ALU_OUT_TMP} = alu_model(bus.SEL_TMP, bus.A, bus.B);
  end

  int         tests_run = 0;
  int         tests_failed = 0;
  logic [7:0] exp_count = 8'd0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Full transaction with RSP_READY high; entered and left at a negedge.
  task automatic run_op(input string nm, input logic [3:0] sel, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp_d,
                        input logic [3:0] exp_f, input bit clr_exec);
    bus.REQ_VALID = 1'b1;
    bus.REQ_SEL   = sel;
    bus.REQ_A     = a;
    bus.REQ_B     = b;
    check($sformatf("%s.req_ready", nm), bus.REQ_READY, 1);
    @(posedge clk);
    @(negedge clk);
    bus.REQ_VALID = 1'b0;
    bus.REQ_SEL   = ~sel;
    bus.REQ_A     = ~a;
    bus.REQ_B     = ~b;
    if (clr_exec) sticky_clr = 1'b1;
    check($sformatf("%s.exec_valid", nm), bus.RSP_VALID, 0);
    check($sformatf("%s.exec_ready", nm), bus.REQ_READY, 0);
    check($sformatf("%s.sel_tmp", nm), bus.SEL_TMP, sel);
    check($sformatf("%s.a", nm), bus.A, a);
    check($sformatf("%s.b", nm), bus.B, b);
    @(posedge clk);
    @(negedge clk);
    sticky_clr = 1'b0;
    check($sformatf("%s.rsp_valid", nm), bus.RSP_VALID, 1);
    check($sformatf("%s.rsp_data", nm), bus.RSP_DATA, exp_d);
    check($sformatf("%s.rsp_flags", nm), bus.RSP_FLAGS, exp_f);
    check($sformatf("%s.resp_ready", nm), bus.REQ_READY, 0);
    @(posedge clk);
    @(negedge clk);
    exp_count = exp_count + 8'd1;
    check($sformatf("%s.done_valid", nm), bus.RSP_VALID, 0);
    check($sformatf("%s.op_count", nm), op_count, exp_count);
    check($sformatf("%s.idle_ready", nm), bus.REQ_READY, 1);
  endtask

  typedef struct {
    string      nm;
    logic [3:0] sel;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_d;
    logic [3:0] exp_f;
  } vec_t;

  vec_t vecs[17];

  initial begin
    vecs[0]  = '{"add_200_100",  OP_ADD,  8'd200, 8'd100, 8'd44,  4'b0010};
    vecs[1]  = '{"sub_9_10",     OP_SUB,  8'd9,   8'd10,  8'd255, 4'b1000};
    vecs[2]  = '{"sub_5_5",      OP_SUB,  8'd5,   8'd5,   8'd0,   4'b0001};
    vecs[3]  = '{"mul_10_7",     OP_MUL,  8'd10,  8'd7,   8'd70,  4'b0000};
    vecs[4]  = '{"mul_20_20",    OP_MUL,  8'd20,  8'd20,  8'd144, 4'b0100};
    vecs[5]  = '{"div_100_7",    OP_DIV,  8'd100, 8'd7,   8'd14,  4'b0000};
    vecs[6]  = '{"shl_3_2",      OP_SHL,  8'd3,   8'd2,   8'd12,  4'b0000};
    vecs[7]  = '{"shr_128_7",    OP_SHR,  8'd128, 8'd7,   8'd1,   4'b0000};
    vecs[8]  = '{"and",          OP_AND,  8'hF0,  8'h3C,  8'h30,  4'b0000};
    vecs[9]  = '{"or",           OP_OR,   8'hF0,  8'h0F,  8'hFF,  4'b0000};
    vecs[10] = '{"xor_zero",     OP_XOR,  8'hAA,  8'hAA,  8'h00,  4'b0001};
    vecs[11] = '{"xnor",         OP_XNOR, 8'hAA,  8'h55,  8'h00,  4'b0001};
    vecs[12] = '{"nand",         OP_NAND, 8'hFF,  8'hFF,  8'h00,  4'b0001};
    vecs[13] = '{"nor",          OP_NOR,  8'h00,  8'h00,  8'hFF,  4'b0000};
    vecs[14] = '{"op_e",         4'hE,    8'd5,   8'd5,   8'h00,  4'b0000};
    vecs[15] = '{"add_200_56",   OP_ADD,  8'd200, 8'd56,  8'h00,  4'b0011};
    vecs[16] = '{"op_f",         4'hF,    8'h12,  8'h34,  8'h00,  4'b0000};

    rst           = 1'b0;
    bus.REQ_VALID = 1'b0;
    bus.REQ_SEL   = 4'h0;
    bus.REQ_A     = 8'h00;
    bus.REQ_B     = 8'h00;
    bus.RSP_READY = 1'b1;
    sticky_clr    = 1'b0;

    #2 rst = 1'b1;
    #1;
    check("rst.req_ready", bus.REQ_READY, 0);
    check("rst.rsp_valid", bus.RSP_VALID, 0);
    check("rst.rsp_data", bus.RSP_DATA, 0);
    check("rst.rsp_flags", bus.RSP_FLAGS, 0);
    check("rst.sel_tmp", bus.SEL_TMP, 0);
    check("rst.a", bus.A, 0);
    check("rst.b", bus.B, 0);
    check("rst.op_count", op_count, 0);
    check("rst.sticky", sticky_flags, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check("rst_release.req_ready", bus.REQ_READY, 1);
    @(negedge clk);

    for (int i = 0; i < 17; i++)
      run_op(vecs[i].nm, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].exp_d, vecs[i].exp_f, 1'b0);

    // Response stall with an extra request that must be ignored.
    bus.RSP_READY = 1'b0;
    bus.REQ_VALID = 1'b1;
    bus.REQ_SEL   = OP_DIV;
    bus.REQ_A     = 8'd11;
    bus.REQ_B     = 8'd0;
    @(posedge clk);
    @(negedge clk);
    bus.REQ_VALID = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stall%0d.rsp_valid", k), bus.RSP_VALID, 1);
      check($sformatf("stall%0d.rsp_data", k), bus.RSP_DATA, 8'd255);
      check($sformatf("stall%0d.rsp_flags", k), bus.RSP_FLAGS, 4'b0100);
      check($sformatf("stall%0d.req_ready", k), bus.REQ_READY, 0);
      bus.REQ_VALID = 1'b1;
      bus.REQ_SEL   = OP_ADD;
      bus.REQ_A     = 8'd1;
      bus.REQ_B     = 8'd1;
      @(posedge clk);
      @(negedge clk);
    end
    check("stall.sel_tmp", bus.SEL_TMP, OP_DIV);
    check("stall.a", bus.A, 8'd11);
    check("stall.b", bus.B, 8'd0);
    check("stall.op_count", op_count, exp_count);
    check("stall.held_data", bus.RSP_DATA, 8'd255);
    bus.REQ_VALID = 1'b0;
    bus.RSP_READY = 1'b1;
    @(posedge clk);
    @(negedge clk);
    exp_count = exp_count + 8'd1;
    check("stall.done_valid", bus.RSP_VALID, 0);
    check("stall.done_count", op_count, exp_count);
    check("stall.done_ready", bus.REQ_READY, 1);
    check("stall.ignored_sel", bus.SEL_TMP, OP_DIV);

    // Reset pulse while MUL 10*7 is executing.
    bus.REQ_VALID = 1'b1;
    bus.REQ_SEL   = OP_MUL;
    bus.REQ_A     = 8'd10;
    bus.REQ_B     = 8'd7;
    @(posedge clk);
    @(negedge clk);
    bus.REQ_VALID = 1'b0;
    check("mulrst.in_exec", bus.A, 8'd10);
    rst = 1'b1;
    #1;
    exp_count = 8'd0;
    check("mulrst.rsp_valid", bus.RSP_VALID, 0);
    check("mulrst.rsp_data", bus.RSP_DATA, 0);
    check("mulrst.rsp_flags", bus.RSP_FLAGS, 0);
    check("mulrst.sel_tmp", bus.SEL_TMP, 0);
    check("mulrst.a", bus.A, 0);
    check("mulrst.b", bus.B, 0);
    check("mulrst.req_ready", bus.REQ_READY, 0);
    check("mulrst.op_count", op_count, 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("mulrst.release_ready", bus.REQ_READY, 1);
    @(negedge clk);
    @(negedge clk);
    check("mulrst.no_rsp", bus.RSP_VALID, 0);
    check("mulrst.no_data", bus.RSP_DATA, 0);
    check("mulrst.no_count", op_count, 0);
    run_op("add_1_1", OP_ADD, 8'd1, 8'd1, 8'd2, 4'b0000, 1'b0);

    // Sticky flags accumulate, clear, and clear+capture keeps only new flags.
    check("sticky.start", sticky_flags, 0);
    run_op("sticky_add", OP_ADD, 8'd200, 8'd56, 8'h00, 4'b0011, 1'b0);
    run_op("sticky_sub", OP_SUB, 8'd9, 8'd10, 8'd255, 4'b1000, 1'b0);
    check("sticky.accum", sticky_flags, STICKY_ON ? 4'b1011 : 4'b0000);
    sticky_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sticky_clr = 1'b0;
    check("sticky.cleared", sticky_flags, 0);
    run_op("sticky_sub2", OP_SUB, 8'd9, 8'd10, 8'd255, 4'b1000, 1'b0);
    check("sticky.reaccum", sticky_flags, STICKY_ON ? 4'b1000 : 4'b0000);
    run_op("sticky_clrcap", OP_ADD, 8'd200, 8'd100, 8'd44, 4'b0010, 1'b1);
    check("sticky.clr_capture", sticky_flags, STICKY_ON ? 4'b0010 : 4'b0000);

    // 256 back-to-back operations: counter wraps, responses 3 cycles apart.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_count = 8'd0;
    bus.RSP_READY = 1'b1;
    bus.REQ_VALID = 1'b1;
    bus.REQ_SEL   = OP_AND;
    bus.REQ_A     = 8'hFF;
    bus.REQ_B     = 8'h5A;
    begin
      int got = 0;
      int cyc = 0;
      int last = -1;
      int spacing_bad = 0;
      while (got < 256 && cyc < 2000) begin
        @(negedge clk);
        cyc++;
        if (bus.RSP_VALID) begin
          got++;
          if (last >= 0 && (cyc - last) != 3) spacing_bad++;
          last = cyc;
          if (got == 256) bus.REQ_VALID = 1'b0;
        end
      end
      check("wrap.responses", got, 256);
      check("wrap.spacing", spacing_bad, 0);
      check("wrap.last_data", bus.RSP_DATA, 8'h5A);
      @(posedge clk);
      @(negedge clk);
      check("wrap.op_count", op_count, 0);
      check("wrap.idle_valid", bus.RSP_VALID, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
